// File: rtl/fifo_drain.sv
// fifo_drain: pulls words out of an upstream FIFO in bursts (auto-burst on
// an occupancy threshold, or a one-shot flush of the current contents) and
// forwards them downstream through a 2-entry skid buffer with valid/ready.
module fifo_drain (
  input  logic        clk,
  input  logic        rst,
  input  logic        fifo_empty,
  input  logic [4:0]  fifo_length,
  input  logic [7:0]  fifo_dataout,
  output logic        readsig,
  input  logic [4:0]  burst_len,
  input  logic        flush,
  output logic        m_valid,
  output logic [7:0]  m_data,
  input  logic        m_ready,
  output logic        busy,
  output logic [15:0] word_count
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [4:0]  remaining;
  logic [4:0]  remaining_next;
  logic        inflight;
  logic [7:0]  buf0;
  logic [7:0]  buf1;
  logic [1:0]  occ;
  logic [7:0]  buf0_next;
  logic [7:0]  buf1_next;
  logic [1:0]  occ_next;
  logic        xfer;
  logic [2:0]  pending;
  logic        auto_hit;

  // Downstream handshake view; outputs are forced quiet while rst is high.
  always_comb begin
    m_valid = 1'b0;
    m_data  = 8'd0;
    busy    = 1'b0;
    if (rst) begin
      m_valid = 1'b0;
      m_data  = 8'd0;
      busy    = 1'b0;
    end else begin
      m_valid = (occ != 2'd0);
      m_data  = buf0;
      busy    = (state != IDLE) || (occ != 2'd0);
    end
  end

  assign xfer = m_valid && m_ready;

  // Pop request: only pop when the word it returns is guaranteed a slot.
  always_comb begin
    pending  = {1'b0, occ} + {2'b00, inflight} - {2'b00, xfer};
    auto_hit = (burst_len != 5'd0) && (burst_len <= 5'd16) && (fifo_length >= burst_len);
    if (!rst && (state == BURST) && (remaining != 5'd0) && !fifo_empty && (pending < 3'd2)) begin
      readsig = 1'b1;
    end else begin
      readsig = 1'b0;
    end
  end

  // Next-state and burst counter; flush is only looked at in IDLE.
  always_comb begin
    state_next     = state;
    remaining_next = remaining;
    case (state)
      IDLE: begin
        if (auto_hit) begin
          state_next     = BURST;
          remaining_next = burst_len;
        end else if (flush && !fifo_empty) begin
          state_next     = BURST;
          remaining_next = fifo_length;
        end else begin
          state_next     = IDLE;
          remaining_next = remaining;
        end
      end
      BURST: begin
        if ((remaining == 5'd0) && !inflight) begin
          state_next     = IDLE;
          remaining_next = 5'd0;
        end else if (readsig) begin
          state_next     = BURST;
          remaining_next = remaining - 5'd1;
        end else begin
          state_next     = BURST;
          remaining_next = remaining;
        end
      end
      default: begin
        state_next     = IDLE;
        remaining_next = 5'd0;
      end
    endcase
  end

  // Skid buffer: retire the head on a transfer, then append the returning word.
  always_comb begin
    buf0_next = buf0;
    buf1_next = buf1;
    occ_next  = occ;
    if (xfer) begin
      buf0_next = buf1;
      occ_next  = occ - 2'd1;
    end else begin
      occ_next  = occ;
    end
    if (inflight) begin
      if (occ_next == 2'd0) begin
        buf0_next = fifo_dataout;
      end else begin
        buf1_next = fifo_dataout;
      end
      occ_next = occ_next + 2'd1;
    end else begin
      buf1_next = buf1_next;
    end
  end

  // State, counters and skid storage registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      remaining  <= 5'd0;
      inflight   <= 1'b0;
      buf0       <= 8'd0;
      buf1       <= 8'd0;
      occ        <= 2'd0;
      word_count <= 16'd0;
    end else begin
      state      <= state_next;
      remaining  <= remaining_next;
      inflight   <= readsig;
      buf0       <= buf0_next;
      buf1       <= buf1_next;
      occ        <= occ_next;
      word_count <= word_count + {15'd0, xfer};
    end
  end

endmodule
